// File: rtl/fetch_stage.sv
// Instruction-fetch stage with its IF/ID pipeline register.
// The PC is redirected by branches and jumps resolved in ID, and those redirects flush IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [15:0] immediate,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [15:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign imem_addr = pc;
  assign immediate = if_id_instr[15:0];
  assign pc_plus4  = pc + 32'd4;

  // A redirect from a bubble in ID is stale, so it only counts when IF/ID is valid.
  // When branch_taken and jump arrive together, the branch target is the one taken.
  always_comb begin
    branch_target   = if_id_pc4 + (imm_ext << 2);
    jump_target     = {if_id_pc4[31:28], jump_index, 2'b00};
    redirect        = if_id_valid & (branch_taken | jump);
    redirect_target = branch_taken ? branch_target : jump_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_RESET;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      flush_count <= 16'd0;
    end else if (redirect) begin
      pc          <= redirect_target;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end else if (!stall) begin
      pc          <= pc_plus4;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes hand-computed post-edge state into a queue
// and a negedge monitor pops and compares it; async reset is checked directly between edges.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] imm_ext = 32'd0;
  logic [25:0] jump_index = 26'd0;
  logic [31:0] imem_data = 32'h2001_1111;
  logic [31:0] imem_addr;
  logic [15:0] immediate;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] flush_count;

  localparam logic [31:0] D = 32'h2001_1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] fc;
    logic [15:0] imm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .imm_ext      (imm_ext),
    .jump_index   (jump_index),
    .imem_data    (imem_data),
    .imem_addr    (imem_addr),
    .immediate    (immediate),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_next(input string nm, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic v, input logic [15:0] fc,
                             input logic [15:0] imm);
    exp_t e;
    e = '{addr: addr, instr: instr, pc4: pc4, valid: v, fc: fc, imm: imm};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic st, input logic bt, input logic jp, input logic [31:0] imm,
                       input logic [25:0] ji, input logic [31:0] data);
    stall        = st;
    branch_taken = bt;
    jump         = jp;
    imm_ext      = imm;
    jump_index   = ji;
    imem_data    = data;
  endtask

  // Drive one cycle's inputs mid-cycle; the expectation describes state after the next rising edge.
  task automatic step(input logic st, input logic bt, input logic jp, input logic [31:0] imm,
                      input logic [25:0] ji, input logic [31:0] data, input string nm,
                      input logic [31:0] addr, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic v, input logic [15:0] fc, input logic [15:0] imm16);
    @(negedge clk);
    #1;
    drive(st, bt, jp, imm, ji, data);
    expect_next(nm, addr, instr, pc4, v, fc, imm16);
  endtask

  task automatic step_nc(input logic bt, input logic jp);
    @(negedge clk);
    #1;
    drive(1'b0, bt, jp, 32'd0, 26'd0, D);
  endtask

  task automatic check_now(input string nm, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic v, input logic [15:0] fc,
                           input logic [15:0] imm);
    check({nm, ".addr"},  imem_addr, addr);
    check({nm, ".instr"}, if_id_instr, instr);
    check({nm, ".pc4"},   if_id_pc4, pc4);
    check({nm, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    check({nm, ".fc"},    {16'd0, flush_count}, {16'd0, fc});
    check({nm, ".imm"},   {16'd0, immediate}, {16'd0, imm});
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_now(nm, e.addr, e.instr, e.pc4, e.valid, e.fc, e.imm);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2;
    check_now("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    expect_next("fetch1", 32'h4, D, 32'h4, 1'b1, 16'd0, 16'h1111);
    step(0, 0, 0, 32'h0, 26'h0, D, "fetch2", 32'h8, D, 32'h8, 1, 16'd0, 16'h1111);
    step(0, 0, 0, 32'h0, 26'h0, D, "fetch3", 32'hC, D, 32'hC, 1, 16'd0, 16'h1111);
    step(0, 0, 0, 32'h0, 26'h0, D, "fetch4", 32'h10, D, 32'h10, 1, 16'd0, 16'h1111);
    // Branch back: 0x10 + (-1 << 2) = 0xC.
    step(0, 1, 0, 32'hFFFF_FFFF, 26'h0, D, "branch_neg", 32'hC, 32'h0, 32'h0, 0, 16'd1, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, 32'h1234_F000, "pre_stall", 32'h10, 32'h1234_F000, 32'h10, 1, 16'd1, 16'hF000);
    step(1, 0, 0, 32'h0, 26'h0, 32'hDEAD_BEEF, "stall1", 32'h10, 32'h1234_F000, 32'h10, 1, 16'd1, 16'hF000);
    step(1, 0, 0, 32'h0, 26'h0, 32'hDEAD_BEEF, "stall2", 32'h10, 32'h1234_F000, 32'h10, 1, 16'd1, 16'hF000);
    step(0, 0, 0, 32'h0, 26'h0, D, "post_stall", 32'h14, D, 32'h14, 1, 16'd1, 16'h1111);
    // 0x14 + 0x3FFF_FFF0 = 0x4000_0004.
    step(0, 1, 0, 32'h0FFF_FFFC, 26'h0, D, "branch_far", 32'h4000_0004, 32'h0, 32'h0, 0, 16'd2, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "fetch_far", 32'h4000_0008, D, 32'h4000_0008, 1, 16'd2, 16'h1111);
    // Branch + jump + stall: 0x4000_0008 + 0x4444 = 0x4000_444C, one flush.
    step(1, 1, 1, 32'h0000_1111, 26'h100, D, "br_jp_st", 32'h4000_444C, 32'h0, 32'h0, 0, 16'd3, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "fetch_444c", 32'h4000_4450, D, 32'h4000_4450, 1, 16'd3, 16'h1111);
    step(1, 0, 1, 32'h0000_1111, 26'h100, D, "jump_st", 32'h4000_0400, 32'h0, 32'h0, 0, 16'd4, 16'h0);
    step(0, 1, 0, 32'h0000_1111, 26'h0, D, "br_on_bubble", 32'h4000_0404, D, 32'h4000_0404, 1, 16'd4, 16'h1111);
    // 0x4000_0404 + 0xBFFF_FBF8 = 0xFFFF_FFFC.
    step(0, 1, 0, 32'h2FFF_FEFE, 26'h0, D, "to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd5, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "pc_wrap", 32'h0, D, 32'h0, 1, 16'd5, 16'h1111);
    for (int i = 0; i < 65529; i++) begin
      step_nc(0, 1);
      step_nc(0, 0);
    end
    step(0, 0, 1, 32'h0, 26'h0, D, "fc_reach_max", 32'h0, 32'h0, 32'h0, 0, 16'hFFFF, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "sat_fetch1", 32'h4, D, 32'h4, 1, 16'hFFFF, 16'h1111);
    step(0, 0, 1, 32'h0, 26'h0, D, "fc_sat1", 32'h0, 32'h0, 32'h0, 0, 16'hFFFF, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "sat_fetch2", 32'h4, D, 32'h4, 1, 16'hFFFF, 16'h1111);
    step(0, 0, 1, 32'h0, 26'h0, D, "fc_sat2", 32'h0, 32'h0, 32'h0, 0, 16'hFFFF, 16'h0);
    step(0, 0, 0, 32'h0, 26'h0, D, "pre_reset", 32'h4, D, 32'h4, 1, 16'hFFFF, 16'h1111);
    step(0, 0, 0, 32'h0, 26'h0, D, "pre_reset2", 32'h8, D, 32'h8, 1, 16'hFFFF, 16'h1111);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1, 1, 32'h0000_1111, 26'h100, D);
    check("resume_addr", imem_addr, 32'h0);
    expect_next("redirect_after_reset", 32'h4, D, 32'h4, 1, 16'd0, 16'h1111);
    step(0, 0, 0, 32'h0, 26'h0, D, "resume2", 32'h8, D, 32'h8, 1, 16'd0, 16'h1111);
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
